// File: rtl/mprj_io_cfg_loader_if.sv
// mprj_io_cfg_loader_if
// Bundles the loader's request/status handshake, register-file read port and
// serial pad-configuration chain signals.
//   start, busy, done            : sequence request and status
//   cfg_addr, cfg_rd, cfg_rdata  : register-file read port (rdata one cycle after rd)
//   serial_clock/data_out/load   : pad configuration chain
// Optional (macro MPRJ_CFG_READBACK_EN): serial_data_in, rb_valid, rb_addr, rb_data.
// Modports: master = loader side, slave = register file / chain side.
interface mprj_io_cfg_loader_if #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13
);
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                start;
    logic                busy;
    logic                done;
    logic [AW-1:0]       cfg_addr;
    logic                cfg_rd;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;
`ifdef MPRJ_CFG_READBACK_EN
    logic                serial_data_in;
    logic                rb_valid;
    logic [AW-1:0]       rb_addr;
    logic [CFG_BITS-1:0] rb_data;

    modport master (
        input  start, cfg_rdata, serial_data_in,
        output busy, done, cfg_addr, cfg_rd, serial_clock, serial_data_out,
               serial_load, rb_valid, rb_addr, rb_data
    );
    modport slave (
        output start, cfg_rdata, serial_data_in,
        input  busy, done, cfg_addr, cfg_rd, serial_clock, serial_data_out,
               serial_load, rb_valid, rb_addr, rb_data
    );
`else
    modport master (
        input  start, cfg_rdata,
        output busy, done, cfg_addr, cfg_rd, serial_clock, serial_data_out,
               serial_load
    );
    modport slave (
        output start, cfg_rdata,
        input  busy, done, cfg_addr, cfg_rd, serial_clock, serial_data_out,
               serial_load
    );
`endif
endinterface

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader
// Programs the user-project GPIO pad configuration chain. On start, reads each
// pad's word from the register file (highest pad first), shifts it MSB first on
// a divided serial clock, then pulses serial_load so all pads latch together.
// Ports:
//   wb_clk_i : system clock (rising edge)
//   wb_rst_i : synchronous active-high reset
//   bus      : mprj_io_cfg_loader_if.master (handshake, regfile port, chain)
// Optional macro MPRJ_CFG_READBACK_EN: captures the chain tail (serial_data_in)
// and reports each pad's previous contents on rb_valid/rb_addr/rb_data.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_FETCH_RD| cfg_rd asserted with cfg_addr = pad pointer
// S_FETCH_CP| capture cfg_rdata into shift register
// S_SHIFT   | shift bits: low phase then high phase, CLK_DIV cycles each
// S_LOAD    | serial_load high for 2*CLK_DIV cycles
// S_DONE    | one-cycle done pulse, busy low
module mprj_io_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_i,
    mprj_io_cfg_loader_if.master bus
);
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int TW = $clog2(2*CLK_DIV + 1);

    localparam logic [TW-1:0] PHASE_LEN = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LOAD_LEN  = TW'(2*CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_BITS - 1);
    localparam logic [AW-1:0] TOP_PAD   = AW'(NUM_PADS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_RD, S_FETCH_CP, S_SHIFT, S_LOAD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q;
    logic [BW-1:0]       bit_q;
    logic [TW-1:0]       tmr_q;
    logic                hi_q;
    logic [CFG_BITS-1:0] shift_q;

    logic tmr_zero, bit_end, last_bit;
    logic busy_c, done_c, rd_c, sclk_c, sdo_c, load_c;

    assign tmr_zero = (tmr_q == '0);
    assign bit_end  = (state_q == S_SHIFT) && hi_q && tmr_zero;
    assign last_bit = bit_end && (bit_q == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        rd_c    = 1'b0;
        sclk_c  = 1'b0;
        sdo_c   = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH_RD;
            end
            S_FETCH_RD: begin
                busy_c  = 1'b1;
                rd_c    = 1'b1;
                state_d = S_FETCH_CP;
            end
            S_FETCH_CP: begin
                busy_c  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy_c = 1'b1;
                sclk_c = hi_q;
                sdo_c  = shift_q[CFG_BITS-1];
                if (last_bit) state_d = (ptr_q == '0) ? S_LOAD : S_FETCH_RD;
            end
            S_LOAD: begin
                busy_c = 1'b1;
                load_c = 1'b1;
                if (tmr_zero) state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: pad pointer, bit counter, phase/load timer and shift register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q   <= '0;
            bit_q   <= '0;
            tmr_q   <= '0;
            hi_q    <= 1'b0;
            shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) ptr_q <= TOP_PAD;
                end
                S_FETCH_CP: begin
                    shift_q <= bus.cfg_rdata;
                    bit_q   <= LAST_BIT;
                    tmr_q   <= PHASE_LEN;
                    hi_q    <= 1'b0;
                end
                S_SHIFT: begin
                    if (!tmr_zero) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else if (!hi_q) begin
                        hi_q  <= 1'b1;
                        tmr_q <= PHASE_LEN;
                    end else begin
                        // End of high phase: next bit starts a fresh low phase,
                        // so data only changes as serial_clock falls.
                        hi_q  <= 1'b0;
                        tmr_q <= PHASE_LEN;
                        if (bit_q != '0) begin
                            bit_q   <= bit_q - 1'b1;
                            shift_q <= {shift_q[CFG_BITS-2:0], 1'b0};
                        end else if (ptr_q != '0) begin
                            ptr_q <= ptr_q - 1'b1;
                        end else begin
                            tmr_q <= LOAD_LEN;
                        end
                    end
                end
                S_LOAD: begin
                    if (!tmr_zero) tmr_q <= tmr_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = busy_c;
    assign bus.done            = done_c;
    assign bus.cfg_rd          = rd_c;
    assign bus.cfg_addr        = ptr_q;
    assign bus.serial_clock    = sclk_c;
    assign bus.serial_data_out = sdo_c;
    assign bus.serial_load     = load_c;

`ifdef MPRJ_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rb_shift_q, rb_data_q;
    logic [AW-1:0]       rb_addr_q;
    logic                rb_valid_q;

    // The tail is sampled on the edge that raises serial_clock, i.e. before the
    // chain shifts, so the bit seen is the one leaving the last pad.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            rb_addr_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            if ((state_q == S_SHIFT) && !hi_q && tmr_zero)
                rb_shift_q <= {rb_shift_q[CFG_BITS-2:0], bus.serial_data_in};
            rb_valid_q <= last_bit;
            if (last_bit) begin
                rb_data_q <= rb_shift_q;
                rb_addr_q <= ptr_q;
            end
        end
    end

    assign bus.rb_valid = rb_valid_q;
    assign bus.rb_addr  = rb_addr_q;
    assign bus.rb_data  = rb_data_q;
`endif
endmodule
